fetch_prefetch_queue: RTL and testbench

- Single-clock fetch stage: generates sequential instruction addresses, issues them over a req/ack memory port, and buffers returned words with their PCs in a DEPTH-entry FIFO.
- The FIFO feeds decode over a valid/ready handshake.
- A branch/flush input redirects the fetch PC, empties the queue and discards any in-flight response.
- Successor of the fixed one-instruction fetch step: parametrised width/depth/step, back-pressure, and redirect support.

---
 rtl/fetch_prefetch_queue.sv | 147 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetch with a req/ack memory port and a prefetch FIFO.
// Redirects flush the queue and drop any response still in flight.
module fetch_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_address,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_read,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instruction,
    output logic [ADDR_W-1:0]        out_pc,
    input  logic                     out_ready,
    input  logic                     br_valid,
    input  logic [ADDR_W-1:0]        br_target,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        DISCARD
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] addr_n;
    logic              req_n;

    logic [ADDR_W-1:0] pc_q  [DEPTH];
    logic [DATA_W-1:0] ins_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_n;

    logic pop;
    logic push;
    logic space;

    assign pop     = out_valid & out_ready & ~br_valid;
    assign push    = (state == WAIT) & mem_ack & ~br_valid;
    assign count_n = q_count - CW'(pop) + CW'(push);
    assign space   = count_n < CW'(DEPTH);

    assign out_instruction = ins_q[rd_ptr];
    assign out_pc          = pc_q[rd_ptr];

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_n      = mem_req;
        addr_n     = mem_address;
        if (br_valid)
            fetch_pc_n = br_target;
        unique case (state)
            ISSUE: begin
                if (br_valid || space) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc_n;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (br_valid) begin
                    if (mem_ack)
                        addr_n = br_target;
                    else
                        state_n = DISCARD;
                end else if (mem_ack) begin
                    fetch_pc_n = fetch_pc + ADDR_W'(PC_STEP);
                    if (space) begin
                        addr_n = fetch_pc_n;
                    end else begin
                        req_n   = 1'b0;
                        state_n = ISSUE;
                    end
                end
            end
            DISCARD: begin
                // Old response is dropped; reissue the latest redirect target.
                if (mem_ack) begin
                    if (br_valid || space) begin
                        addr_n  = fetch_pc_n;
                        state_n = WAIT;
                    end else begin
                        req_n   = 1'b0;
                        state_n = ISSUE;
                    end
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ISSUE;
            fetch_pc    <= RESET_PC;
            mem_req     <= 1'b0;
            mem_address <= RESET_PC;
            q_count     <= '0;
            out_valid   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            mem_req     <= req_n;
            mem_address <= addr_n;
            if (br_valid) begin
                q_count   <= '0;
                out_valid <= 1'b0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                q_count   <= count_n;
                out_valid <= count_n != '0;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            pc_q[wr_ptr]  <= fetch_pc;
            ins_q[wr_ptr] <= mem_read;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vectors, reset/wrap sequences
// and random traffic against a transaction-level queue model.
module tb_fetch_prefetch_queue;

    localparam int D = 4;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_address;
    logic        mem_ack;
    logic [31:0] mem_read;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        br_valid;
    logic [31:0] br_target;
    logic [2:0]  q_count;

    logic        rst2_n;
    logic        req2;
    logic [31:0] addr2;
    logic        vld2;
    logic [31:0] ins2;
    logic [31:0] pc2;
    logic [2:0]  cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk1 = ~clk1;

    fetch_prefetch_queue #(.DEPTH(D)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .mem_req(mem_req), .mem_address(mem_address),
        .mem_ack(mem_ack), .mem_read(mem_read),
        .out_valid(out_valid), .out_instruction(out_instruction),
        .out_pc(out_pc), .out_ready(out_ready),
        .br_valid(br_valid), .br_target(br_target),
        .q_count(q_count)
    );

    fetch_prefetch_queue #(.DEPTH(D), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk1(clk1), .rst_n(rst2_n),
        .mem_req(req2), .mem_address(addr2),
        .mem_ack(1'b1), .mem_read(32'hAAAA_5555),
        .out_valid(vld2), .out_instruction(ins2),
        .out_pc(pc2), .out_ready(1'b1),
        .br_valid(1'b0), .br_target(32'h0),
        .q_count(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic r, input logic b,
                                input logic [31:0] t, input logic rq,
                                input logic [31:0] ad, input logic v,
                                input logic [31:0] p, input logic [2:0] c);
        vec_t x;
        x.ack = a; x.rdy = r; x.br = b; x.tgt = t;
        x.req = rq; x.addr = ad; x.vld = v; x.pc = p; x.cnt = c;
        return x;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_req;
    logic        m_disc;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;

    // Queue-level reference: one outstanding request, words land in order.
    task automatic model_step();
        bit pop, ackd, push;
        int sz;
        pop  = mq.size() > 0 && out_ready && !br_valid;
        ackd = m_req && mem_ack;
        push = ackd && !m_disc && !br_valid;
        sz   = mq.size() - int'(pop) + int'(push);
        if (br_valid) begin
            mq.delete();
            m_fpc = br_target;
            if (!m_req || mem_ack) begin
                m_req  = 1'b1;
                m_addr = br_target;
                m_disc = 1'b0;
            end else begin
                m_disc = 1'b1;
            end
        end else begin
            if (pop)
                void'(mq.pop_front());
            if (push) begin
                mq.push_back('{m_addr, mem_read});
                m_fpc = m_addr + 32'd4;
            end
            if (ackd) begin
                m_disc = 1'b0;
                m_req  = sz < D;
                if (sz < D)
                    m_addr = m_fpc;
            end else if (!m_req && sz < D) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        out_ready = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        mem_read  = '0;
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
    endtask

    vec_t vt[21];

    initial begin
        rst2_n = 1'b0;
        vt[0]  = mk(1, 1, 0, 0,      1, 32'h0,   0, 0,       0);
        vt[1]  = mk(1, 1, 0, 0,      1, 32'h4,   1, 32'h0,   1);
        vt[2]  = mk(1, 1, 0, 0,      1, 32'h8,   1, 32'h4,   1);
        vt[3]  = mk(1, 1, 0, 0,      1, 32'hC,   1, 32'h8,   1);
        vt[4]  = mk(1, 0, 0, 0,      1, 32'h10,  1, 32'h8,   2);
        vt[5]  = mk(1, 0, 0, 0,      1, 32'h14,  1, 32'h8,   3);
        vt[6]  = mk(1, 0, 0, 0,      0, 32'h0,   1, 32'h8,   4);
        vt[7]  = mk(1, 0, 0, 0,      0, 32'h0,   1, 32'h8,   4);
        vt[8]  = mk(0, 1, 0, 0,      1, 32'h18,  1, 32'hC,   3);
        vt[9]  = mk(1, 1, 0, 0,      1, 32'h1C,  1, 32'h10,  3);
        vt[10] = mk(0, 0, 1, 32'h100, 1, 32'h1C, 0, 0,       0);
        vt[11] = mk(0, 1, 0, 0,      1, 32'h1C,  0, 0,       0);
        vt[12] = mk(1, 1, 0, 0,      1, 32'h100, 0, 0,       0);
        vt[13] = mk(0, 1, 0, 0,      1, 32'h100, 0, 0,       0);
        vt[14] = mk(1, 0, 0, 0,      1, 32'h104, 1, 32'h100, 1);
        vt[15] = mk(1, 1, 1, 32'h200, 1, 32'h200, 0, 0,      0);
        vt[16] = mk(0, 1, 0, 0,      1, 32'h200, 0, 0,       0);
        vt[17] = mk(0, 1, 1, 32'h300, 1, 32'h200, 0, 0,      0);
        vt[18] = mk(0, 1, 1, 32'h400, 1, 32'h200, 0, 0,      0);
        vt[19] = mk(1, 1, 0, 0,      1, 32'h400, 0, 0,       0);
        vt[20] = mk(1, 0, 0, 0,      1, 32'h404, 1, 32'h400, 1);

        do_reset();
        chk("reset req", mem_req, 0);
        chk("reset addr", mem_address, 0);
        chk("reset valid", out_valid, 0);
        chk("reset cnt", q_count, 0);

        // Memory responder returns a word tagged with its own address.
        for (int i = 0; i < 21; i++) begin
            mem_ack   = vt[i].ack;
            out_ready = vt[i].rdy;
            br_valid  = vt[i].br;
            br_target = vt[i].tgt;
            mem_read  = {16'hC0DE, mem_address[15:0]};
            @(posedge clk1);
            @(negedge clk1);
            chk($sformatf("v%0d req", i), mem_req, vt[i].req);
            if (vt[i].req)
                chk($sformatf("v%0d addr", i), mem_address, vt[i].addr);
            chk($sformatf("v%0d valid", i), out_valid, vt[i].vld);
            chk($sformatf("v%0d cnt", i), q_count, vt[i].cnt);
            if (vt[i].vld) begin
                chk($sformatf("v%0d pc", i), out_pc, vt[i].pc);
                chk($sformatf("v%0d ins", i), out_instruction,
                    {16'hC0DE, vt[i].pc[15:0]});
            end
        end

        // Reset dropped in the middle of an outstanding request.
        do_reset();
        mem_ack   = 1'b1;
        out_ready = 1'b0;
        repeat (4) @(negedge clk1);
        chk("pre-rst cnt", q_count, 3);
        chk("pre-rst req", mem_req, 1);
        chk("pre-rst addr", mem_address, 32'hC);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst req", mem_req, 0);
        chk("async rst cnt", q_count, 0);
        chk("async rst valid", out_valid, 0);
        chk("async rst addr", mem_address, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("late ack req", mem_req, 1);
        chk("late ack addr", mem_address, 0);
        chk("late ack cnt", q_count, 0);
        @(negedge clk1);
        chk("restart cnt", q_count, 1);
        chk("restart pc", out_pc, 0);
        chk("restart addr", mem_address, 32'h4);
        mem_ack = 1'b0;

        // PC wrap from the top of the address space.
        rst2_n = 1'b1;
        @(negedge clk1);
        chk("wrap addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk1);
        chk("wrap addr1", addr2, 32'h0);
        chk("wrap pc0", pc2, 32'hFFFF_FFFC);
        @(negedge clk1);
        chk("wrap addr2", addr2, 32'h4);
        chk("wrap pc1", pc2, 32'h0);
        chk("wrap cnt", cnt2, 1);

        do_reset();
        mq.delete();
        m_req  = 1'b0;
        m_disc = 1'b0;
        m_addr = '0;
        m_fpc  = '0;
        for (int i = 0; i < 3000; i++) begin
            mem_ack   = $urandom_range(0, 1) == 1;
            if (((i / 400) % 2) == 1)
                out_ready = $urandom_range(0, 3) == 0;
            else
                out_ready = $urandom_range(0, 3) != 0;
            br_valid  = $urandom_range(0, 24) == 0;
            br_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                    : ($urandom & 32'hFFFF_FFFC);
            mem_read  = $urandom;
            @(posedge clk1);
            model_step();
            @(negedge clk1);
            chk("rnd req", mem_req, m_req);
            if (m_req)
                chk("rnd addr", mem_address, m_addr);
            chk("rnd cnt", q_count, mq.size());
            chk("rnd valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rnd pc", out_pc, mq[0].pc);
                chk("rnd ins", out_instruction, mq[0].d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
